lsu_bus_if: RTL

- Load/store unit downstream of the single-cycle RV32I core. It consumes the core's memory-access requests: address, store data, funct3 and destination register.
- Each request becomes one word-aligned, byte-enabled transaction on a req/ack data-memory bus.
- Load data is returned to the core sign- or zero-extended, tagged with its rd index for register-file writeback.
- The core holds the issuing instruction while req_ready is low.

---
 rtl/lsu_bus_if.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_bus_if.sv
// lsu_bus_if: load/store unit between the single-cycle RV32I core and a
// req/ack data-memory bus. Each accepted request becomes one word-aligned,
// byte-enabled bus transaction. Load results return sign- or zero-extended
// and tagged with their rd index.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_we, req_funct3, req_addr, req_wdata, req_rd
//                         : request handshake and fields from the core
//   resp_valid, resp_rd, resp_data : one-cycle load writeback pulse
//   misaligned            : one-cycle pulse, request rejected (illegal/misaligned)
//   bus_err               : one-cycle pulse, bus timeout (0 unless LSU_TIMEOUT_EN)
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata, mem_ack, mem_rdata
//                         : data-memory bus, fields held until mem_ack
//
// Build option: define LSU_TIMEOUT_EN to abort a bus transaction that has
// waited TIMEOUT cycles without mem_ack.
module lsu_bus_if #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [4:0]      req_rd,
   output logic            resp_valid,
   output logic [4:0]      resp_rd,
   output logic [XLEN-1:0] resp_data,
   output logic            misaligned,
   output logic            bus_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUS, RESP, ERR} state_t;

   state_t          state;
   logic [2:0]      f3_q;
   logic [1:0]      off_q;
   logic [4:0]      rd_q;

   logic            req_legal;
   logic            req_aligned;
   logic [3:0]      req_be;
   logic [XLEN-1:0] req_wrep;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] load_ext;

   assign req_ready = (state == IDLE);

   // Request decode: legality, alignment, byte enables, lane replication.
   always_comb begin
      req_legal = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: req_legal = 1'b1;
         3'b100, 3'b101:         req_legal = !req_we;
         default:                req_legal = 1'b0;
      endcase

      req_aligned = 1'b1;
      req_be      = 4'b1111;
      req_wrep    = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            req_be   = 4'b0001 << req_addr[1:0];
            req_wrep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            req_aligned = !req_addr[0];
            req_be      = 4'b0011 << {req_addr[1], 1'b0};
            req_wrep    = {2{req_wdata[15:0]}};
         end
         default: begin
            req_aligned = (req_addr[1:0] == 2'b00);
            req_be      = 4'b1111;
            req_wrep    = req_wdata;
         end
      endcase
   end

   // Load lane select and extension, using the offset/funct3 latched at accept.
   always_comb begin
      ld_byte = mem_rdata[7:0];
      case (off_q)
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      load_ext = mem_rdata;
      case (f3_q)
         3'b000:  load_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b001:  load_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b100:  load_ext = {{(XLEN-8){1'b0}}, ld_byte};
         3'b101:  load_ext = {{(XLEN-16){1'b0}}, ld_half};
         default: load_ext = mem_rdata;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
   logic [CW-1:0] tmo_cnt;
`else
   logic unused_timeout;
   assign bus_err        = 1'b0;
   assign unused_timeout = (TIMEOUT != 0);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         f3_q       <= '0;
         off_q      <= '0;
         rd_q       <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_rd    <= '0;
         resp_data  <= '0;
         misaligned <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         bus_err    <= 1'b0;
         tmo_cnt    <= '0;
`endif
      end else begin
         // Pulse outputs default low; a state transition raises them for one cycle.
         resp_valid <= 1'b0;
         misaligned <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         bus_err    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (req_legal && req_aligned) begin
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                     mem_be    <= req_be;
                     mem_wdata <= req_wrep;
                     f3_q      <= req_funct3;
                     off_q     <= req_addr[1:0];
                     rd_q      <= req_rd;
`ifdef LSU_TIMEOUT_EN
                     tmo_cnt   <= '0;
`endif
                     state     <= BUS;
                  end else begin
                     misaligned <= 1'b1;
                     state      <= ERR;
                  end
               end
            end
            BUS: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (mem_we) begin
                     state <= IDLE;
                  end else begin
                     resp_valid <= 1'b1;
                     resp_rd    <= rd_q;
                     resp_data  <= load_ext;
                     state      <= RESP;
                  end
               end
`ifdef LSU_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  // A timed-out load still completes writeback (with 0) so the core cannot stall.
                  mem_req <= 1'b0;
                  bus_err <= 1'b1;
                  state   <= IDLE;
                  if (!mem_we) begin
                     resp_valid <= 1'b1;
                     resp_rd    <= rd_q;
                     resp_data  <= '0;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            RESP:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
